// File: rtl/cpu_ext_loader.sv
// Host-side loader: byte-stream commands drive the CPU external memory ports and run enable.
// Optional macro LOADER_ACK_EN adds a one-byte acknowledge after every legal command.
module cpu_ext_loader #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        srst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        enable,
  output logic        busy,
  output logic        err
);
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_HDR    = 4'd1;
  localparam logic [3:0] S_LOAD   = 4'd2;
  localparam logic [3:0] S_WRITE  = 4'd3;
  localparam logic [3:0] S_RUN    = 4'd4;
  localparam logic [3:0] S_RDREQ  = 4'd5;
  localparam logic [3:0] S_RDWAIT = 4'd6;
  localparam logic [3:0] S_SEND   = 4'd7;
  localparam logic [3:0] S_ACK    = 4'd8;
`ifdef LOADER_ACK_EN
  localparam logic [3:0] S_DONE = S_ACK;
`else
  localparam logic [3:0] S_DONE = S_IDLE;
`endif
  localparam logic [7:0] LAT_LAST   = 8'(MEM_RD_LAT - 1);
  localparam logic [7:0] CMD_LOAD_I = 8'h01;
  localparam logic [7:0] CMD_LOAD_D = 8'h02;
  localparam logic [7:0] CMD_RUN    = 8'h03;
  localparam logic [7:0] CMD_DUMP   = 8'h04;

  logic [3:0]  state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [1:0]  hdr_q, hdr_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  byte_q, byte_d;
  logic [63:0] word_q, word_d;
  logic [7:0]  lat_q, lat_d;

  logic        active;
  logic        cmd_legal;
  logic        last_byte;
  logic [15:0] hdr_cnt;

  assign active    = ~srst;
  assign cmd_legal = (rx_data >= CMD_LOAD_I) && (rx_data <= CMD_DUMP);
  assign last_byte = (cmd_q == CMD_LOAD_I) ? (byte_q == 3'd3) : (byte_q == 3'd7);
  assign hdr_cnt   = {rx_data, cnt_q[7:0]};

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    hdr_d   = hdr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    word_d  = word_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && cmd_legal) begin
          cmd_d   = rx_data;
          hdr_d   = 2'd0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (rx_valid) begin
          hdr_d = hdr_q + 2'd1;
          case (hdr_q)
            2'd0:    idx_d[7:0]  = rx_data;
            2'd1:    idx_d[15:8] = rx_data;
            2'd2:    cnt_d[7:0]  = rx_data;
            default: begin
              cnt_d  = hdr_cnt;
              byte_d = 3'd0;
              lat_d  = 8'd0;
              if (hdr_cnt == 16'd0)
                state_d = S_DONE;
              else if (cmd_q == CMD_LOAD_I || cmd_q == CMD_LOAD_D)
                state_d = S_LOAD;
              else if (cmd_q == CMD_RUN)
                state_d = S_RUN;
              else
                state_d = S_RDREQ;
            end
          endcase
        end
      end
      S_LOAD: begin
        // Little-endian assembly: byte n of the word lands in bits [8n+7:8n].
        if (rx_valid) begin
          word_d[{byte_q, 3'b000} +: 8] = rx_data;
          byte_d = byte_q + 3'd1;
          if (last_byte) begin
            byte_d  = 3'd0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 16'd1;
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? S_DONE : S_LOAD;
      end
      S_RUN: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = S_DONE;
      end
      S_RDREQ: begin
        lat_d   = 8'd0;
        state_d = S_RDWAIT;
      end
      S_RDWAIT: begin
        if (lat_q == LAT_LAST) begin
          word_d  = rdata_ext_2;
          byte_d  = 3'd0;
          state_d = S_SEND;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          byte_d = byte_q + 3'd1;
          if (byte_q == 3'd7) begin
            idx_d   = idx_q + 16'd1;
            cnt_d   = cnt_q - 16'd1;
            state_d = (cnt_q == 16'd1) ? S_DONE : S_RDREQ;
          end
        end
      end
      S_ACK: begin
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= S_IDLE;
      cmd_q   <= 8'd0;
      hdr_q   <= 2'd0;
      idx_q   <= 16'd0;
      cnt_q   <= 16'd0;
      byte_q  <= 3'd0;
      word_q  <= 64'd0;
      lat_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      hdr_q   <= hdr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      lat_q   <= lat_d;
    end
  end

  // Every output is forced low while srst is high, even before the state register clears.
  assign rx_ready  = active & (state_q == S_IDLE || state_q == S_HDR || state_q == S_LOAD);
  assign tx_valid  = active & (state_q == S_SEND || state_q == S_ACK);
  assign tx_data   = !active            ? 8'd0 :
                     (state_q == S_ACK)  ? {4'hA, cmd_q[3:0]} :
                     (state_q == S_SEND) ? word_q[{byte_q, 3'b000} +: 8] : 8'd0;
  assign wen_ext     = active & (state_q == S_WRITE) & (cmd_q == CMD_LOAD_I);
  assign wen_ext_2   = active & (state_q == S_WRITE) & (cmd_q == CMD_LOAD_D);
  assign ren_ext_2   = active & (state_q == S_RDREQ);
  assign ren_ext     = 1'b0;
  assign addr_ext    = wen_ext ? {46'b0, idx_q, 2'b00} : 64'd0;
  assign wdata_ext   = wen_ext ? word_q[31:0] : 32'd0;
  assign addr_ext_2  = (wen_ext_2 || ren_ext_2) ? {45'b0, idx_q, 3'b000} : 64'd0;
  assign wdata_ext_2 = wen_ext_2 ? word_q : 64'd0;
  assign enable      = active & (state_q == S_RUN);
  assign busy        = active & (state_q != S_IDLE);
  assign err         = active & (state_q == S_IDLE) & rx_valid & ~cmd_legal;
endmodule
